i2c_write_master: RTL and testbench

- Parametrised I2C master that writes one 7-bit device address plus NUM_BYTES data bytes per transaction. Primary use is configuring the audio codec's control registers.
- Successor to the fixed 3-byte, undivided-clock writer. Adds:
  - a programmable SCL divider with 4-phase bit timing,
  - a valid/ready command interface,
  - ACK checking on every byte, with automatic NACK retry,
  - done and error reporting.
- Sits between the codec init sequencer (command source) and the FPGA_I2C_SCLK/FPGA_I2C_SDAT pins.

---
 rtl/i2c_pkg.sv | 28 ++
 rtl/i2c_tick_gen.sv | 34 +++
 rtl/i2c_write_master.sv | 187 ++++++++++++++++++
 tb/tb_i2c_write_master.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C write master.
//   state_t       : controller states (3-bit encoding)
//   P0..P3        : quarter-period phase numbers inside one bus element
//   I2C_WRITE_BIT : R/W bit appended to the slave address (write = 0)
//   addr_byte()   : builds the first byte on the wire from a 7-bit address
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    SHIFT = 3'd2,
    ACK   = 3'd3,
    STOP  = 3'd4,
    GAP   = 3'd5
  } state_t;

  localparam logic [1:0] P0 = 2'd0;
  localparam logic [1:0] P1 = 2'd1;
  localparam logic [1:0] P2 = 2'd2;
  localparam logic [1:0] P3 = 2'd3;

  localparam logic I2C_WRITE_BIT = 1'b0;

  function automatic logic [7:0] addr_byte(input logic [6:0] addr);
    return {addr, I2C_WRITE_BIT};
  endfunction

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-SCL-period tick generator.
//   clk    : system clock
//   KEY    : synchronous active-low reset
//   enable : counter runs while high; held at zero while low
//   tick   : one-cycle strobe on the terminal count (every cycle if CLK_DIV=1)
module i2c_tick_gen #(
  parameter int unsigned CLK_DIV = 125
) (
  input  logic clk,
  input  logic KEY,
  input  logic enable,
  output logic tick
);

  localparam int unsigned   CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;

  // Holding the count at zero while disabled means every transaction
  // starts from a cleared divider without a separate clear input.
  always_ff @(posedge clk) begin
    if (!KEY || !enable) begin
      r_cnt <= '0;
    end else if (r_cnt == TERM) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = enable && (r_cnt == TERM);

endmodule

// File: rtl/i2c_write_master.sv
// I2C write master: START, {DEV_ADDR,W}, NUM_BYTES data bytes, STOP, with
// per-byte ACK checking and automatic retry of the whole frame on NACK.
//   clk           : system clock
//   KEY           : synchronous active-low reset (aborts, bus released)
//   cmd_valid     : command request, accepted when cmd_ready is high
//   cmd_ready     : high only while idle
//   cmd_data      : payload, first byte in the top 8 bits, MSB first
//   busy          : high from accept until done/ack_err
//   done          : one-cycle pulse on successful completion
//   ack_err       : one-cycle pulse when retries are exhausted
//   attempts      : attempts used by the last transaction
//   FPGA_I2C_SCLK : SCL, push-pull
//   FPGA_I2C_SDAT : SDA, open-drain (drives 0 or Z)
module i2c_write_master
  import i2c_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR  = 7'h1A,
  parameter int unsigned NUM_BYTES = 2,
  parameter int unsigned CLK_DIV   = 125,
  parameter int unsigned MAX_RETRY = 2
) (
  input  logic                   clk,
  input  logic                   KEY,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [8*NUM_BYTES-1:0] cmd_data,
  output logic                   busy,
  output logic                   done,
  output logic                   ack_err,
  output logic [2:0]             attempts,
  output logic                   FPGA_I2C_SCLK,
  inout  wire                    FPGA_I2C_SDAT
);

  localparam int unsigned PW        = 8 * NUM_BYTES;
  localparam logic [2:0]  LAST_BYTE = 3'(NUM_BYTES);
  localparam logic [7:0]  ADDR_BYTE = addr_byte(DEV_ADDR);

  state_t          r_state;
  state_t          w_state_next;
  logic [1:0]      r_phase;
  logic [2:0]      r_bit;
  logic [2:0]      r_byte;
  logic [7:0]      r_shift;
  logic [PW-1:0]   r_payload;
  logic [PW-1:0]   r_latched;
  logic [2:0]      r_attempts;
  logic            r_nack;
  logic            r_sample;
  logic            r_done;
  logic            r_err;
  logic            w_run;
  logic            w_tick;
  logic            w_last_ph;
  logic            w_retry;
  logic            w_scl;
  logic            w_sda_low;

  assign w_run     = (r_state != IDLE);
  assign w_last_ph = w_tick && (r_phase == P3);
  assign w_retry   = (32'(r_attempts) <= MAX_RETRY);

  i2c_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk    (clk),
    .KEY    (KEY),
    .enable (w_run),
    .tick   (w_tick)
  );

  always_ff @(posedge clk) begin
    if (!KEY) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_scl        = 1'b1;
    w_sda_low    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (cmd_valid) w_state_next = START;
      end
      START: begin
        w_scl     = (r_phase != P3);
        w_sda_low = (r_phase == P2) || (r_phase == P3);
        if (w_last_ph) w_state_next = SHIFT;
      end
      SHIFT: begin
        w_scl     = (r_phase == P1) || (r_phase == P2);
        w_sda_low = !r_shift[7];
        if (w_last_ph && (r_bit == 3'd0)) w_state_next = ACK;
      end
      ACK: begin
        w_scl = (r_phase == P1) || (r_phase == P2);
        if (w_last_ph) begin
          w_state_next = (r_sample || (r_byte == LAST_BYTE)) ? STOP : SHIFT;
        end
      end
      STOP: begin
        w_scl     = (r_phase != P0);
        w_sda_low = (r_phase != P3);
        if (w_last_ph) w_state_next = GAP;
      end
      GAP: begin
        if (w_last_ph) w_state_next = (r_nack && w_retry) ? START : IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // r_payload is a consumable copy of the command; r_latched keeps the
  // original so a retry can replay the same bytes.
  always_ff @(posedge clk) begin
    if (!KEY) begin
      r_phase    <= P0;
      r_bit      <= '0;
      r_byte     <= '0;
      r_shift    <= '0;
      r_payload  <= '0;
      r_latched  <= '0;
      r_attempts <= '0;
      r_nack     <= 1'b0;
      r_sample   <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (r_state == IDLE) begin
        if (cmd_valid) begin
          r_latched  <= cmd_data;
          r_payload  <= cmd_data;
          r_shift    <= ADDR_BYTE;
          r_attempts <= 3'd1;
          r_nack     <= 1'b0;
          r_bit      <= 3'd7;
          r_byte     <= '0;
          r_phase    <= P0;
        end
      end else if (w_tick) begin
        r_phase <= r_phase + 2'd1;
        if (r_state == SHIFT && r_phase == P3) begin
          r_shift <= {r_shift[6:0], 1'b0};
          r_bit   <= r_bit - 3'd1;
        end
        if (r_state == ACK && r_phase == P2) begin
          r_sample <= FPGA_I2C_SDAT;
        end
        if (r_state == ACK && r_phase == P3) begin
          if (r_sample) begin
            r_nack <= 1'b1;
          end else if (r_byte != LAST_BYTE) begin
            r_shift   <= r_payload[PW-1 -: 8];
            r_payload <= r_payload << 8;
            r_byte    <= r_byte + 3'd1;
          end
        end
        if (r_state == GAP && r_phase == P3) begin
          if (!r_nack) begin
            r_done <= 1'b1;
          end else if (w_retry) begin
            r_attempts <= r_attempts + 3'd1;
            r_nack     <= 1'b0;
            r_shift    <= ADDR_BYTE;
            r_payload  <= r_latched;
            r_byte     <= '0;
            r_bit      <= 3'd7;
          end else begin
            r_err <= 1'b1;
          end
        end
      end
    end
  end

  assign cmd_ready     = (r_state == IDLE);
  assign busy          = w_run;
  assign done          = r_done;
  assign ack_err       = r_err;
  assign attempts      = r_attempts;
  assign FPGA_I2C_SCLK = w_scl;
  assign FPGA_I2C_SDAT = w_sda_low ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_write_master.sv
// Self-checking bench for i2c_write_master. Two instances: bus 0 is a
// 2-byte writer with a short divider, bus 1 is the CLK_DIV=1, 4-byte corner.
// A bus-level slave decodes START/STOP/bytes and answers ACK/NACK from a
// per-bus policy; expectations come from a transaction-level model.
module tb_i2c_write_master;

  localparam int MAXR = 2;

  logic        clk = 1'b0;
  logic        KEY = 1'b0;
  logic [1:0]  vld = '0;
  logic [15:0] data0 = '0;
  logic [31:0] data1 = '0;
  logic [1:0]  rdy, bsy, dn, er, scl;
  logic [2:0]  att [2];
  wire         sda0, sda1;
  logic [1:0]  sl_low = '0;
  logic [1:0]  sv;

  pullup (sda0);
  pullup (sda1);
  assign sda0 = sl_low[0] ? 1'b0 : 1'bz;
  assign sda1 = sl_low[1] ? 1'b0 : 1'bz;
  assign sv   = {sda1, sda0};

  always #5 clk = ~clk;

  i2c_write_master #(.DEV_ADDR(7'h1A), .NUM_BYTES(2), .CLK_DIV(5), .MAX_RETRY(MAXR)) u_dut0 (
    .clk(clk), .KEY(KEY), .cmd_valid(vld[0]), .cmd_ready(rdy[0]), .cmd_data(data0),
    .busy(bsy[0]), .done(dn[0]), .ack_err(er[0]), .attempts(att[0]),
    .FPGA_I2C_SCLK(scl[0]), .FPGA_I2C_SDAT(sda0)
  );

  i2c_write_master #(.DEV_ADDR(7'h1A), .NUM_BYTES(4), .CLK_DIV(1), .MAX_RETRY(MAXR)) u_dut1 (
    .clk(clk), .KEY(KEY), .cmd_valid(vld[1]), .cmd_ready(rdy[1]), .cmd_data(data1),
    .busy(bsy[1]), .done(dn[1]), .ack_err(er[1]), .attempts(att[1]),
    .FPGA_I2C_SCLK(scl[1]), .FPGA_I2C_SDAT(sda1)
  );

  function automatic int cd_of(input int b);
    return (b == 0) ? 5 : 1;
  endfunction

  function automatic int nb_of(input int b);
    return (b == 0) ? 2 : 4;
  endfunction

  // ---------------- bus monitor / slave ----------------
  int         starts [2] = '{0, 0};
  int         stops  [2] = '{0, 0};
  int         bitc   [2] = '{0, 0};
  int         bidx   [2] = '{0, 0};
  int         nlog   [2] = '{0, 0};
  int         hlen   [2] = '{0, 0};
  int         hn     [2] = '{0, 0};
  int         hbad   [2] = '{0, 0};
  logic       sp     [2] = '{1'b1, 1'b1};
  logic       dp     [2] = '{1'b1, 1'b1};
  logic       inb    [2] = '{1'b0, 1'b0};
  logic [7:0] cur    [2];
  logic [7:0] blog   [2][512];
  int         pol_na [2] = '{0, 0};
  int         pol_k  [2] = '{0, 0};
  int         fbase  [2] = '{0, 0};

  always @(negedge clk) begin
    for (int b = 0; b < 2; b++) begin
      logic s_c, d_c;
      s_c = scl[b];
      d_c = sv[b];
      if (s_c && sp[b] && dp[b] && !d_c) begin
        starts[b] = starts[b] + 1;
        bitc[b] = 0;
        bidx[b] = 0;
        inb[b]  = 1'b0;
      end else if (s_c && sp[b] && !dp[b] && d_c) begin
        stops[b] = stops[b] + 1;
        inb[b]   = 1'b0;
      end
      if (s_c && !sp[b]) begin
        hlen[b] = 1;
        inb[b]  = 1'b1;
        if (bitc[b] < 8) begin
          cur[b]  = {cur[b][6:0], d_c};
          bitc[b] = bitc[b] + 1;
          if (bitc[b] == 8 && nlog[b] < 512) begin
            blog[b][nlog[b]] = cur[b];
            nlog[b] = nlog[b] + 1;
          end
        end else begin
          bitc[b] = 9;
        end
      end else if (s_c) begin
        hlen[b] = hlen[b] + 1;
      end
      if (!s_c && sp[b]) begin
        if (inb[b]) begin
          hn[b] = hn[b] + 1;
          if (hlen[b] != 2 * cd_of(b)) hbad[b] = hbad[b] + 1;
        end
        inb[b] = 1'b0;
        if (bitc[b] == 8) begin
          sl_low[b] = !(((starts[b] - fbase[b]) <= pol_na[b]) && (bidx[b] == pol_k[b]));
        end else if (bitc[b] == 9) begin
          sl_low[b] = 1'b0;
          bitc[b]   = 0;
          bidx[b]   = bidx[b] + 1;
        end
      end
      sp[b] = s_c;
      dp[b] = d_c;
    end
  end

  // ---------------- checking ----------------
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Transaction-level model: the slave NACKs byte k on attempts 1..na;
  // each attempt is START + 9 ticks*4 per byte sent + STOP + GAP.
  int         m_att, m_lat, m_n, m_frames;
  bit         m_ok;
  logic [7:0] m_log [64];

  task automatic model_txn(input int b, input logic [31:0] pl, input int na, input int k);
    int   nb, ticks;
    bit   nacked;
    logic [7:0] by;
    nb = nb_of(b);
    ticks = 0;
    m_n = 0; m_ok = 1'b0; m_att = 0; m_frames = 0;
    for (int a = 1; a <= MAXR + 1; a++) begin
      nacked = 1'b0;
      m_att = a;
      m_frames++;
      ticks += 12;
      for (int i = 0; i <= nb; i++) begin
        by = (i == 0) ? 8'h34 : pl[8*(nb-i) +: 8];
        m_log[m_n] = by;
        m_n++;
        ticks += 36;
        if (a <= na && i == k) begin
          nacked = 1'b1;
          break;
        end
      end
      if (!nacked) begin
        m_ok = 1'b1;
        break;
      end
    end
    m_lat = ticks * cd_of(b) + 1;
  endtask

  task automatic run_txn(input int b, input logic [31:0] pl, input int na, input int k,
                         input bit inj, input int e_att, input bit e_ok, input int e_lat,
                         input string nm);
    int cyc, lat, nd, ne, both, badr, st0, sp0, n0, hn0, hb0;
    int x_att, x_lat;
    bit x_ok;
    model_txn(b, pl, na, k);
    x_att = (e_att < 0) ? m_att : e_att;
    x_ok  = (e_att < 0) ? m_ok  : e_ok;
    x_lat = (e_att < 0) ? m_lat : e_lat;
    pol_na[b] = na;
    pol_k[b]  = k;
    @(negedge clk);
    st0 = starts[b]; sp0 = stops[b]; n0 = nlog[b]; hn0 = hn[b]; hb0 = hbad[b];
    fbase[b] = starts[b];
    chk({nm, "_ready_idle"}, rdy[b], 1);
    vld[b] = 1'b1;
    if (b == 0) data0 = pl[15:0];
    else        data1 = pl;
    @(negedge clk);
    vld[b] = 1'b0;
    cyc = 1;
    chk({nm, "_busy_after_accept"}, bsy[b], 1);
    chk({nm, "_attempts_after_accept"}, att[b], 1);
    lat = -1; nd = 0; ne = 0; both = 0; badr = 0;
    while (cyc < 20000) begin
      if (bsy[b] && rdy[b]) badr++;
      if (dn[b]) nd++;
      if (er[b]) ne++;
      if (dn[b] && er[b]) both++;
      if ((dn[b] || er[b]) && lat < 0) begin
        lat = cyc;
        chk({nm, "_ready_at_end"}, {bsy[b], rdy[b]}, 2'b01);
      end
      if (inj && b == 0) begin
        if (cyc == 20) begin
          vld[0] = 1'b1;
          data0  = 16'hFFFF;
        end
        if (cyc == 120) vld[0] = 1'b0;
        if (cyc > 20 && cyc < 120 && rdy[0]) badr++;
      end
      if (lat >= 0 && cyc >= lat + 10) break;
      @(negedge clk);
      cyc++;
    end
    chk({nm, "_latency"}, lat, x_lat);
    chk({nm, "_done_pulses"}, nd, x_ok ? 1 : 0);
    chk({nm, "_err_pulses"}, ne, x_ok ? 0 : 1);
    chk({nm, "_done_and_err"}, both, 0);
    chk({nm, "_ready_while_busy"}, badr, 0);
    chk({nm, "_attempts"}, att[b], x_att);
    chk({nm, "_busy_after"}, bsy[b], 0);
    chk({nm, "_starts"}, starts[b] - st0, m_frames);
    chk({nm, "_stops"}, stops[b] - sp0, m_frames);
    chk({nm, "_byte_count"}, nlog[b] - n0, m_n);
    for (int i = 0; i < m_n && (n0 + i) < nlog[b]; i++) begin
      chk($sformatf("%s_byte%0d", nm, i), blog[b][n0 + i], m_log[i]);
    end
    chk({nm, "_scl_high_count"}, hn[b] - hn0, m_n * 9);
    chk({nm, "_scl_high_width_bad"}, hbad[b] - hb0, 0);
  endtask

  typedef struct {
    int          b;
    logic [31:0] pl;
    int          na;
    int          k;
    bit          inj;
    int          att;
    bit          ok;
    int          lat;
  } vec_t;

  vec_t vt [5];

  initial begin
    int i0;
    repeat (3) @(negedge clk);
    for (int b = 0; b < 2; b++) begin
      chk($sformatf("rst%0d_scl", b), scl[b], 1);
      chk($sformatf("rst%0d_sda", b), sv[b], 1);
      chk($sformatf("rst%0d_ready", b), rdy[b], 1);
      chk($sformatf("rst%0d_busy", b), bsy[b], 0);
      chk($sformatf("rst%0d_done_err", b), {dn[b], er[b]}, 0);
      chk($sformatf("rst%0d_attempts", b), att[b], 0);
    end
    KEY = 1'b1;
    repeat (2) @(negedge clk);

    // bus, payload, nack-attempts, nack-byte, inject, attempts, ok, latency
    vt[0] = '{0, 32'h0000_1E00, 0, 0, 1'b0, 1, 1'b1, 601};
    vt[1] = '{0, 32'h0000_1E00, 7, 0, 1'b0, 3, 1'b0, 721};
    vt[2] = '{0, 32'h0000_1E00, 1, 1, 1'b0, 2, 1'b1, 1021};
    vt[3] = '{0, 32'h0000_0C00, 0, 0, 1'b1, 1, 1'b1, 601};
    vt[4] = '{1, 32'hDEAD_BEEF, 0, 0, 1'b0, 1, 1'b1, 193};
    for (int i = 0; i < 5; i++) begin
      run_txn(vt[i].b, vt[i].pl, vt[i].na, vt[i].k, vt[i].inj,
              vt[i].att, vt[i].ok, vt[i].lat, $sformatf("vec%0d", i));
    end

    // Reset while SCL is high on data bit 4 of the address byte.
    pol_na[0] = 0;
    @(negedge clk);
    fbase[0] = starts[0];
    vld[0] = 1'b1;
    data0  = 16'h1E00;
    @(negedge clk);
    vld[0] = 1'b0;
    i0 = 0;
    while (i0 < 2000 && !(bitc[0] == 4 && scl[0])) begin
      @(negedge clk);
      i0++;
    end
    chk("rstmid_reach_bit4", bitc[0], 4);
    KEY = 1'b0;
    @(negedge clk);
    KEY = 1'b1;
    chk("rstmid_scl", scl[0], 1);
    chk("rstmid_sda", sv[0], 1);
    chk("rstmid_busy", bsy[0], 0);
    chk("rstmid_ready", rdy[0], 1);
    chk("rstmid_attempts", att[0], 0);
    repeat (3) @(negedge clk);
    run_txn(0, 32'h0000_1E00, 0, 0, 1'b0, 1, 1'b1, 601, "after_rst");

    for (int i = 0; i < 8; i++) begin
      run_txn(0, {16'h0, 16'($urandom)}, int'($urandom_range(0, 3)),
              int'($urandom_range(0, 2)), 1'b0, -1, 1'b0, 0, $sformatf("rnd0_%0d", i));
    end
    for (int i = 0; i < 4; i++) begin
      run_txn(1, $urandom, int'($urandom_range(0, 3)),
              int'($urandom_range(0, 4)), 1'b0, -1, 1'b0, 0, $sformatf("rnd1_%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
